// File: rtl/extend_extractor.sv
// extend_extractor: receive-side partner of the extend-bit replacer.
// Walks the video byte stream MSB-first under control of the count stream
// ({ext, skip[6:0]}), pulls out each flagged bit, restores its polarity and
// packs the recovered bits MSB-first into bytes for the sign output FIFO.
module extend_extractor #(
  parameter bit INVERT  = 1'b1,
  parameter bit PAD_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] vid_in,
  input  logic       vid_empty,
  output logic       vid_rd,
  input  logic [7:0] cnt_in,
  input  logic       cnt_empty,
  output logic       cnt_rd,
  input  logic       flush_in,
  input  logic       out_afull,
  output logic [7:0] sign_out,
  output logic       sign_wr,
  output logic       busy
);

  // Holding registers for the FIFO words (data only, no reset needed).
  logic [7:0] byte_q, byte_d;
  logic [7:0] cnt_q, cnt_d;

  // Control state.
  logic       byte_vld_q, byte_vld_d;
  logic       cnt_vld_q, cnt_vld_d;
  logic       vid_pend_q, vid_pend_d;
  logic       cnt_pend_q, cnt_pend_d;
  logic [3:0] rem_q, rem_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] acc_cnt_q, acc_cnt_d;
  logic [7:0] sign_out_q, sign_out_d;
  logic       sign_wr_q, sign_wr_d;

  // Combinational helpers.
  logic       module_en;
  logic       do_op;
  logic       ext;
  logic [6:0] skip;
  logic [6:0] rem_ext;
  logic [3:0] rem_left;
  logic       byte_consume;
  logic       cnt_consume;
  logic       ext_fire;
  logic       ext_bit;
  logic       bit_val;
  logic [7:0] acc_next;
  logic [3:0] acc_cnt_next;
  logic       vid_rd_c;
  logic       cnt_rd_c;

  // Fill the unused LSBs of a partial byte with the pad value.
  function automatic logic [7:0] pad_fill(input logic [7:0] acc, input logic [3:0] used);
    logic [7:0] r;
    r = acc;
    for (int i = 0; i < 8; i++) begin
      if (i + int'(used) < 8) r[i] = PAD_BIT;
    end
    return r;
  endfunction

  // Decode the current operation, FIFO reads and the packing path.
  always_comb begin
    module_en    = clk_en & ~out_afull;
    ext          = cnt_q[7];
    skip         = cnt_q[6:0];
    rem_ext      = {3'b000, rem_q};
    rem_left     = rem_q - skip[3:0] - 4'd1;
    do_op        = module_en & byte_vld_q & cnt_vld_q;

    byte_d       = byte_q;
    cnt_d        = cnt_q;
    byte_vld_d   = byte_vld_q;
    cnt_vld_d    = cnt_vld_q;
    vid_pend_d   = vid_pend_q;
    cnt_pend_d   = cnt_pend_q;
    rem_d        = rem_q;
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    sign_out_d   = sign_out_q;
    sign_wr_d    = 1'b0;
    byte_consume = 1'b0;
    cnt_consume  = 1'b0;
    ext_fire     = 1'b0;
    ext_bit      = 1'b0;

    if (do_op) begin
      if (skip >= rem_ext) begin
        // SKIP_BYTE: the target lies beyond this byte; keep the count.
        cnt_d        = {ext, skip - rem_ext};
        byte_consume = 1'b1;
        rem_d        = 4'd8;
      end else if (ext) begin
        // EXTRACT: the marked bit sits at index rem-1-skip.
        ext_bit     = byte_q[rem_left[2:0]];
        ext_fire    = 1'b1;
        cnt_consume = 1'b1;
        if (rem_left == 4'd0) begin
          byte_consume = 1'b1;
          rem_d        = 4'd8;
        end else begin
          rem_d = rem_left;
        end
      end else begin
        // ADVANCE: plain skip inside the byte (skip=0 is a no-op consume).
        cnt_consume = 1'b1;
        rem_d       = rem_q - skip[3:0];
      end
    end

    vid_rd_c = ~rst & module_en & ~vid_empty & (~byte_vld_q | byte_consume) & ~vid_pend_q;
    cnt_rd_c = ~rst & module_en & ~cnt_empty & (~cnt_vld_q | cnt_consume) & ~cnt_pend_q;

    if (module_en) begin
      if (byte_consume) byte_vld_d = 1'b0;
      if (cnt_consume)  cnt_vld_d  = 1'b0;
      if (vid_pend_q) begin
        byte_d     = vid_in;
        byte_vld_d = 1'b1;
      end
      if (cnt_pend_q) begin
        cnt_d     = cnt_in;
        cnt_vld_d = 1'b1;
      end
      vid_pend_d = vid_rd_c;
      cnt_pend_d = cnt_rd_c;
    end

    bit_val      = INVERT ? ~ext_bit : ext_bit;
    acc_next     = acc_q;
    acc_cnt_next = {1'b0, acc_cnt_q};
    if (ext_fire) begin
      acc_next[3'd7 - acc_cnt_q] = bit_val;
      acc_cnt_next               = {1'b0, acc_cnt_q} + 4'd1;
    end

    if (module_en) begin
      if (acc_cnt_next == 4'd8) begin
        // A full byte always wins over a simultaneous flush.
        sign_out_d = acc_next;
        sign_wr_d  = 1'b1;
        acc_d      = 8'h00;
        acc_cnt_d  = 3'd0;
      end else if (flush_in && (acc_cnt_next != 4'd0)) begin
        sign_out_d = pad_fill(acc_next, acc_cnt_next);
        sign_wr_d  = 1'b1;
        acc_d      = 8'h00;
        acc_cnt_d  = 3'd0;
      end else begin
        acc_d     = acc_next;
        acc_cnt_d = acc_cnt_next[2:0];
      end
    end
  end

  // Data holding registers.
  always_ff @(posedge clk) begin
    byte_q <= byte_d;
    cnt_q  <= cnt_d;
  end

  // Control, position and packing state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_vld_q <= 1'b0;
      cnt_vld_q  <= 1'b0;
      vid_pend_q <= 1'b0;
      cnt_pend_q <= 1'b0;
      rem_q      <= 4'd8;
      acc_q      <= 8'h00;
      acc_cnt_q  <= 3'd0;
      sign_out_q <= 8'h00;
      sign_wr_q  <= 1'b0;
    end else begin
      byte_vld_q <= byte_vld_d;
      cnt_vld_q  <= cnt_vld_d;
      vid_pend_q <= vid_pend_d;
      cnt_pend_q <= cnt_pend_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      sign_out_q <= sign_out_d;
      sign_wr_q  <= sign_wr_d;
    end
  end

  assign vid_rd   = vid_rd_c;
  assign cnt_rd   = cnt_rd_c;
  assign sign_out = sign_out_q;
  assign sign_wr  = sign_wr_q;
  assign busy     = byte_vld_q | cnt_vld_q | (acc_cnt_q != 3'd0);

endmodule

// File: tb/tb_extend_extractor.sv
// Testbench for extend_extractor: two instances (INVERT=0/PAD=0 and
// INVERT=1/PAD=1) share one pair of FIFO models and identical stimulus.
module tb_extend_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       flush_in = 1'b0;
  logic       out_afull = 1'b0;
  logic       vid_empty = 1'b1;
  logic       cnt_empty = 1'b1;
  logic [7:0] vid_in = 8'h00;
  logic [7:0] cnt_in = 8'h00;

  logic       vid_rd_a, cnt_rd_a, sign_wr_a, busy_a;
  logic       vid_rd_b, cnt_rd_b, sign_wr_b, busy_b;
  logic [7:0] sign_out_a, sign_out_b;

  extend_extractor #(.INVERT(1'b0), .PAD_BIT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .vid_in(vid_in), .vid_empty(vid_empty),
    .vid_rd(vid_rd_a), .cnt_in(cnt_in), .cnt_empty(cnt_empty), .cnt_rd(cnt_rd_a),
    .flush_in(flush_in), .out_afull(out_afull), .sign_out(sign_out_a),
    .sign_wr(sign_wr_a), .busy(busy_a));

  extend_extractor #(.INVERT(1'b1), .PAD_BIT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .vid_in(vid_in), .vid_empty(vid_empty),
    .vid_rd(vid_rd_b), .cnt_in(cnt_in), .cnt_empty(cnt_empty), .cnt_rd(cnt_rd_b),
    .flush_in(flush_in), .out_afull(out_afull), .sign_out(sign_out_b),
    .sign_wr(sign_wr_b), .busy(busy_b));

  int n_chk = 0;
  int n_fail = 0;

  // FIFO models: first-word data appears the cycle after the read strobe.
  logic [7:0] vq[$];
  logic [7:0] cq[$];
  int nreads = 0;
  always @(posedge clk) begin
    if (vid_rd_a && vq.size() > 0) begin
      vid_in <= vq.pop_front();
      nreads <= nreads + 1;
    end
    if (cnt_rd_a && cq.size() > 0) cnt_in <= cq.pop_front();
    vid_empty <= (vq.size() == 0);
    cnt_empty <= (cq.size() == 0);
  end

  // Output capture and strobe-after-stall watch.
  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];
  logic en_prev = 1'b1;
  always @(posedge clk) en_prev <= clk_en & ~out_afull;
  always @(negedge clk) begin
    if (!rst) begin
      if (sign_wr_a) cap_a.push_back(sign_out_a);
      if (sign_wr_b) cap_b.push_back(sign_out_b);
      if (!en_prev) begin
        n_chk++;
        if (sign_wr_a || sign_wr_b) begin
          n_fail++;
          $display("FAIL wr_after_stall: sign_wr a=%0b b=%0b required 0", sign_wr_a, sign_wr_b);
        end
      end
      if (vid_rd_a !== vid_rd_b || cnt_rd_a !== cnt_rd_b) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_match: a=%0b/%0b b=%0b/%0b", vid_rd_a, cnt_rd_a, vid_rd_b, cnt_rd_b);
      end
    end
  end

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int nbase = 0;
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush_in = 1'b0;
    vq.delete();
    cq.delete();
    tick(2);
    rst = 1'b0;
    cap_a.delete();
    cap_b.delete();
    nbase = nreads;
  endtask

  // Run until the count FIFO is drained, optionally with random stalls.
  task automatic drain(input bit rnd);
    int t;
    t = 0;
    while (cq.size() > 0 && t < 3000) begin
      if (rnd) begin
        clk_en    = ($urandom_range(0, 3) != 0);
        out_afull = ($urandom_range(0, 4) == 0);
      end else begin
        clk_en    = 1'b1;
        out_afull = 1'b0;
      end
      tick(1);
      t++;
    end
    if (t >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d counts left, required 0", cq.size());
    end
    clk_en    = 1'b1;
    out_afull = 1'b0;
    tick(60);
  endtask

  task automatic do_flush();
    clk_en    = 1'b1;
    out_afull = 1'b0;
    flush_in  = 1'b1;
    tick(1);
    flush_in  = 1'b0;
    tick(4);
  endtask

  // Reference model: absolute bit position walk over the stream.
  logic [7:0] mv[$];
  logic [7:0] mc[$];
  bit         mbits[$];
  logic [7:0] pk[$];

  task automatic model_bits();
    int pos;
    logic [7:0] w;
    mbits.delete();
    pos = 0;
    foreach (mc[i]) begin
      pos += int'(mc[i][6:0]);
      if (mc[i][7]) begin
        w = mv[pos / 8];
        mbits.push_back(w[7 - (pos % 8)]);
        pos++;
      end
    end
  endtask

  task automatic model_pack(input bit inv, input bit pad);
    logic [7:0] acc;
    int n;
    pk.delete();
    acc = 8'h00;
    n = 0;
    foreach (mbits[i]) begin
      acc[7 - n] = inv ? ~mbits[i] : mbits[i];
      n++;
      if (n == 8) begin
        pk.push_back(acc);
        acc = 8'h00;
        n = 0;
      end
    end
    if (n > 0) begin
      for (int j = 0; j < 8 - n; j++) acc[j] = pad;
      pk.push_back(acc);
    end
  endtask

  typedef struct packed {
    logic [31:0] vid;
    logic [2:0]  nvid;
    logic [63:0] cnt;
    logic [3:0]  ncnt;
    logic        flush;
    logic [1:0]  exp_wr;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [2:0]  exp_reads;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] so_hold;
    logic       busy_hold;
    int         ncnt, total, nbytes;
    logic [7:0] ca;

    // vid bytes, nvid, counts, ncnt, flush, writes, exp A, exp B, vid reads
    tbl[0] = '{32'hA511_0000, 3'd2, 64'h82 << 56, 4'd1, 1'b1, 2'd1, 8'h80, 8'h7F, 3'd1};
    tbl[1] = '{32'hFF40_1200, 3'd3, 64'h89 << 56, 4'd1, 1'b1, 2'd1, 8'h80, 8'h7F, 3'd2};
    tbl[2] = '{32'h5555_5500, 3'd3, 64'h8080_8080_8080_8080, 4'd8, 1'b0, 2'd1, 8'h55, 8'hAA, 3'd2};
    tbl[3] = '{32'h0080_7700, 3'd3, 64'h88 << 56, 4'd1, 1'b1, 2'd1, 8'h80, 8'h7F, 3'd2};
    tbl[4] = '{32'hFF00_0000, 3'd1, 64'h03 << 56, 4'd1, 1'b1, 2'd0, 8'h00, 8'h00, 3'd1};
    tbl[5] = '{32'h0133_4400, 3'd3, 64'h87 << 56, 4'd1, 1'b1, 2'd1, 8'h80, 8'h7F, 3'd2};
    tbl[6] = '{32'h4099_0000, 3'd2, 64'h8080 << 48, 4'd2, 1'b1, 2'd1, 8'h40, 8'hBF, 3'd1};

    // Reset state.
    tick(1);
    check8("rst_sign_out", sign_out_a, 8'h00);
    check8("rst_flags", {3'b0, sign_wr_a, busy_a, vid_rd_a, cnt_rd_a, busy_b}, 8'h00);
    rst = 1'b0;
    tick(1);

    // Directed table.
    foreach (tbl[i]) begin
      do_reset();
      for (int j = 0; j < int'(tbl[i].nvid); j++) vq.push_back(tbl[i].vid[31 - 8*j -: 8]);
      for (int j = 0; j < int'(tbl[i].ncnt); j++) cq.push_back(tbl[i].cnt[63 - 8*j -: 8]);
      drain(1'b0);
      if (tbl[i].flush) do_flush(); else tick(4);
      checki($sformatf("vec%0d_writes_a", i), cap_a.size(), int'(tbl[i].exp_wr));
      checki($sformatf("vec%0d_writes_b", i), cap_b.size(), int'(tbl[i].exp_wr));
      if (cap_a.size() > 0) check8($sformatf("vec%0d_out_a", i), cap_a[0], tbl[i].exp_a);
      if (cap_b.size() > 0) check8($sformatf("vec%0d_out_b", i), cap_b[0], tbl[i].exp_b);
      checki($sformatf("vec%0d_vid_reads", i), nreads - nbase, int'(tbl[i].exp_reads));
    end

    // Stall in the middle of a run of extractions.
    do_reset();
    vq.push_back(8'h55); vq.push_back(8'h55);
    for (int j = 0; j < 8; j++) cq.push_back(8'h80);
    clk_en = 1'b1;
    tick(6);
    out_afull = 1'b1;
    #1;
    checki("stall_rd", {vid_rd_a, cnt_rd_a}, 0);
    so_hold = sign_out_a;
    busy_hold = busy_a;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      checki("stall_rd_hold", {vid_rd_a, cnt_rd_a, sign_wr_a}, 0);
      check8("stall_hold", {6'b0, busy_a, 1'b0} | sign_out_a, {6'b0, busy_hold, 1'b0} | so_hold);
    end
    out_afull = 1'b0;
    drain(1'b0);
    checki("stall_writes", cap_a.size(), 1);
    if (cap_a.size() > 0) check8("stall_out_a", cap_a[0], 8'h55);
    if (cap_b.size() > 0) check8("stall_out_b", cap_b[0], 8'hAA);

    // Reset with three bits held in the accumulator.
    do_reset();
    vq.push_back(8'hFF); vq.push_back(8'hFF);
    for (int j = 0; j < 3; j++) cq.push_back(8'h80);
    drain(1'b0);
    checki("pre_rst_busy", busy_a, 1);
    rst = 1'b1;
    #1;
    checki("mid_rst_flags", {sign_wr_a, busy_a, vid_rd_a, cnt_rd_a}, 0);
    vq.delete();
    cq.delete();
    tick(2);
    rst = 1'b0;
    cap_a.delete();
    cap_b.delete();
    do_flush();
    checki("post_rst_flush_writes", cap_a.size() + cap_b.size(), 0);
    checki("post_rst_busy", busy_a, 0);

    // Randomized streams against the position-walk model.
    for (int trial = 0; trial < 40; trial++) begin
      do_reset();
      mv.delete();
      mc.delete();
      ncnt = $urandom_range(1, 12);
      total = 0;
      for (int j = 0; j < ncnt; j++) begin
        ca = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 20))};
        mc.push_back(ca);
        total += int'(ca[6:0]) + int'(ca[7]);
      end
      nbytes = total / 8 + 2;
      for (int j = 0; j < nbytes; j++) mv.push_back(8'($urandom));
      foreach (mv[j]) vq.push_back(mv[j]);
      foreach (mc[j]) cq.push_back(mc[j]);
      model_bits();
      drain(1'b1);
      do_flush();
      model_pack(1'b0, 1'b0);
      checki($sformatf("rnd%0d_writes_a", trial), cap_a.size(), pk.size());
      foreach (pk[k]) if (k < cap_a.size()) check8($sformatf("rnd%0d_a[%0d]", trial, k), cap_a[k], pk[k]);
      model_pack(1'b1, 1'b1);
      checki($sformatf("rnd%0d_writes_b", trial), cap_b.size(), pk.size());
      foreach (pk[k]) if (k < cap_b.size()) check8($sformatf("rnd%0d_b[%0d]", trial, k), cap_b[k], pk[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
